// File: rtl/jk_excitation_driver_if.sv
// rtl/jk_excitation_driver_if.sv - target command handshake between control logic and the J/K driver
interface jk_excitation_driver_if #(
    parameter int W = 4
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] target;

    modport master (
        output in_valid,
        output target,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  target,
        output in_ready
    );
endinterface

// File: rtl/jk_excitation_driver.sv
// rtl/jk_excitation_driver.sv - drives J/K pairs of a jkff bank to a target value, verifies, retries
// Optional feature macro: JK_TOGGLE_EN (toggle-code excitation instead of set/reset codes).
module jk_excitation_driver #(
    parameter int W         = 4,
    parameter int MAX_RETRY = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    jk_excitation_driver_if.slave  cmd,
    input  logic [W-1:0]           q_fb,
    output logic [W-1:0]           j,
    output logic [W-1:0]           k,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_CHECK,
        S_DONE,
        S_FAIL
    } state_t;

    state_t        state_q;
    logic [W-1:0]  tgt_q;
    logic [RW-1:0] retry_q;
    logic          in_ready_q;
    logic          busy_q;
    logic          done_q;
    logic          err_q;
    logic [W-1:0]  j_d;
    logic [W-1:0]  k_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            tgt_q      <= '0;
            retry_q    <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd.in_valid) begin
                        tgt_q      <= cmd.target;
                        retry_q    <= '0;
                        state_q    <= S_DRIVE;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                S_DRIVE: state_q <= S_CHECK;
                S_CHECK: begin
                    if (q_fb == tgt_q) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else if (retry_q < RW'(MAX_RETRY)) begin
                        retry_q <= retry_q + RW'(1);
                        state_q <= S_DRIVE;
                    end else begin
                        state_q <= S_FAIL;
                        err_q   <= 1'b1;
                    end
                end
                S_DONE, S_FAIL: begin
                    state_q    <= S_IDLE;
                    busy_q     <= 1'b0;
                    in_ready_q <= 1'b1;
                end
                default: begin
                    state_q    <= S_IDLE;
                    busy_q     <= 1'b0;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Excitation uses the live bank value; the bank is stable until the edge that ends DRIVE.
    always_comb begin
        j_d = '0;
        k_d = '0;
        if (state_q == S_DRIVE) begin
`ifdef JK_TOGGLE_EN
            j_d = tgt_q ^ q_fb;
            k_d = tgt_q ^ q_fb;
`else
            j_d = tgt_q & ~q_fb;
            k_d = ~tgt_q & q_fb;
`endif
        end
    end

    assign j            = j_d;
    assign k            = k_d;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign cmd.in_ready = in_ready_q;
endmodule

// File: tb/tb_jk_excitation_driver.sv
// tb/tb_jk_excitation_driver.sv - directed vectors for jk_excitation_driver against a jkff bank model
module tb_jk_excitation_driver;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] q_fb, j, k;
    logic       busy, done, err;

    logic [3:0] bank_q;
    logic       stuck0 = 1'b0;
    logic       ld = 1'b0;
    logic [3:0] ld_val = 4'b0000;

    int tests = 0;
    int fails = 0;

    jk_excitation_driver_if #(.W(4)) cmd_if ();

    jk_excitation_driver #(.W(4), .MAX_RETRY(2)) dut (
        .clk   (clk),
        .reset (reset),
        .cmd   (cmd_if),
        .q_fb  (q_fb),
        .j     (j),
        .k     (k),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    always #5 clk = ~clk;

    assign q_fb = stuck0 ? (bank_q & 4'b1110) : bank_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bank_q <= 4'b0000;
        end else if (ld) begin
            bank_q <= ld_val;
        end else begin
            for (int i = 0; i < 4; i++) begin
                case ({j[i], k[i]})
                    2'b10:   bank_q[i] <= 1'b1;
                    2'b01:   bank_q[i] <= 1'b0;
                    2'b11:   bank_q[i] <= ~q_fb[i];
                    default: bank_q[i] <= q_fb[i];
                endcase
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [3:0] v);
        @(negedge clk);
        ld = 1'b1;
        ld_val = v;
        @(negedge clk);
        ld = 1'b0;
    endtask

    typedef struct {
        logic [3:0] init;
        logic [3:0] tgt;
        logic [3:0] exp_j;
        logic [3:0] exp_k;
    } vec_t;

    vec_t vecs[5];
    int   drive_cnt;
    int   err_at;
    int   done_seen;
    int   done_at[2];
    int   ndone;
    logic rdy_bad;
    logic [3:0] j2;

    initial begin
        cmd_if.in_valid = 1'b0;
        cmd_if.target   = 4'b0000;
`ifdef JK_TOGGLE_EN
        vecs[0] = '{4'b0000, 4'b1010, 4'b1010, 4'b1010};
        vecs[1] = '{4'b1010, 4'b0101, 4'b1111, 4'b1111};
        vecs[2] = '{4'b0110, 4'b0110, 4'b0000, 4'b0000};
        vecs[3] = '{4'b1111, 4'b0000, 4'b1111, 4'b1111};
        vecs[4] = '{4'b1100, 4'b1001, 4'b0101, 4'b0101};
`else
        vecs[0] = '{4'b0000, 4'b1010, 4'b1010, 4'b0000};
        vecs[1] = '{4'b1010, 4'b0101, 4'b0101, 4'b1010};
        vecs[2] = '{4'b0110, 4'b0110, 4'b0000, 4'b0000};
        vecs[3] = '{4'b1111, 4'b0000, 4'b0000, 4'b1111};
        vecs[4] = '{4'b1100, 4'b1001, 4'b0001, 4'b0100};
`endif
        #12;
        chk("reset_in_ready", {31'd0, cmd_if.in_ready}, 1);
        chk("reset_busy", {31'd0, busy}, 0);
        chk("reset_jk", {24'd0, j, k}, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", {31'd0, cmd_if.in_ready}, 1);
        chk("idle_done_err", {30'd0, done, err}, 0);

        for (int v = 0; v < 5; v++) begin
            preload(vecs[v].init);
            cmd_if.in_valid = 1'b1;
            cmd_if.target   = vecs[v].tgt;
            chk("v_ready_before", {31'd0, cmd_if.in_ready}, 1);
            @(negedge clk);
            cmd_if.in_valid = 1'b0;
            chk("v_drive_j", {28'd0, j}, {28'd0, vecs[v].exp_j});
            chk("v_drive_k", {28'd0, k}, {28'd0, vecs[v].exp_k});
            chk("v_drive_busy_rdy", {30'd0, busy, cmd_if.in_ready}, 2'b10);
            @(negedge clk);
            chk("v_check_jk", {24'd0, j, k}, 0);
            chk("v_check_qfb", {28'd0, q_fb}, {28'd0, vecs[v].tgt});
            chk("v_check_done", {31'd0, done}, 0);
            @(negedge clk);
            chk("v_done_pulse", {29'd0, done, err, busy}, 3'b101);
            @(negedge clk);
            chk("v_after_done", {29'd0, done, busy, cmd_if.in_ready}, 3'b001);
        end

        // Stuck bit: three DRIVE attempts then err on cycle 7 after accept.
        preload(4'b0000);
        stuck0 = 1'b1;
        cmd_if.in_valid = 1'b1;
        cmd_if.target   = 4'b0001;
        drive_cnt = 0;
        err_at    = -1;
        done_seen = 0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            cmd_if.in_valid = 1'b0;
            if (j == 4'b0001) drive_cnt++;
            if (err && err_at < 0) err_at = c;
            else if (err) err_at = 100;
            if (done) done_seen++;
        end
        chk("stuck_drive_count", drive_cnt, 3);
        chk("stuck_err_cycle", err_at, 7);
        chk("stuck_no_done", done_seen, 0);
        chk("stuck_idle_ready", {31'd0, cmd_if.in_ready}, 1);
        stuck0 = 1'b0;

        // Asynchronous reset mid-command, during CHECK.
        preload(4'b0000);
        cmd_if.in_valid = 1'b1;
        cmd_if.target   = 4'b0110;
        @(negedge clk);
        cmd_if.in_valid = 1'b0;
        @(negedge clk);
        chk("abort_in_check_busy", {31'd0, busy}, 1);
        #2 reset = 1'b1;
        #1;
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_jk", {24'd0, j, k}, 0);
        @(negedge clk);
        reset = 1'b0;
        done_seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done || err) done_seen++;
        end
        chk("abort_no_pulse", done_seen, 0);
        chk("abort_ready", {30'd0, cmd_if.in_ready, busy}, 2'b10);

        // Back-to-back with in_valid held high.
        preload(4'b0000);
        cmd_if.in_valid = 1'b1;
        cmd_if.target   = 4'b0011;
        ndone   = 0;
        rdy_bad = 1'b0;
        j2      = 4'b0000;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (c == 1) cmd_if.target = 4'b1100;
            if (c == 5) begin
                j2 = j;
                cmd_if.in_valid = 1'b0;
            end
            if (busy && cmd_if.in_ready) rdy_bad = 1'b1;
            if (done) begin
                if (ndone < 2) done_at[ndone] = c;
                ndone++;
            end
        end
        chk("b2b_done_count", ndone, 2);
        chk("b2b_first_done", done_at[0], 3);
        chk("b2b_second_done", done_at[1], 7);
        chk("b2b_ready_low_busy", {31'd0, rdy_bad}, 0);
`ifdef JK_TOGGLE_EN
        chk("b2b_second_j", {28'd0, j2}, 4'b1111);
`else
        chk("b2b_second_j", {28'd0, j2}, 4'b1100);
`endif
        chk("b2b_final_bank", {28'd0, q_fb}, 4'b1100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
